// File: rtl/cmp_add_div8_pkg.sv
// cmp_add_div8_pkg
// Shared definitions for the adder / comparator / sequential divider block.
//   DATA_W      : reference operand width of the block
//   ITER_W      : width of the divider iteration counter at DATA_W
//   div_state_e : divider control states
package cmp_add_div8_pkg;

    localparam int DATA_W = 8;
    localparam int ITER_W = $clog2(DATA_W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_e;

endpackage

// File: rtl/div8_seq.sv
// div8_seq
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : divide request, accepted only when idle
//   a_i, b_i        : dividend / divisor, captured on acceptance
//   busy_o          : divide in progress
//   done_o          : one-cycle pulse, results valid
//   quo_o, rem_o    : quotient / remainder, held until the next done
//   dbz_o           : last completed divide had a zero divisor
module div8_seq
    import cmp_add_div8_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             dbz_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [WIDTH-1:0] dvd_q;    // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] acc_q;    // partial remainder
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   part_d;
    logic [WIDTH:0]   trial_d;
    logic             fits_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] dvd_d;

    // One restoring step. An explicit compare is used rather than the
    // borrow bit: with a zero divisor the partial remainder is unbounded
    // and the borrow would be wrong; the compare yields quotient all ones
    // and a remainder equal to the dividend.
    always_comb begin
        part_d  = {acc_q, dvd_q[WIDTH-1]};
        trial_d = part_d - {1'b0, dvs_q};
        fits_d  = (part_d >= {1'b0, dvs_q});
        acc_d   = fits_d ? trial_d[WIDTH-1:0] : part_d[WIDTH-1:0];
        dvd_d   = {dvd_q[WIDTH-2:0], fits_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            quo_o   <= '0;
            rem_o   <= '0;
            dbz_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        dvd_q   <= a_i;
                        dvs_q   <= b_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_o  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    dvd_q <= dvd_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        quo_o   <= dvd_d;
                        rem_o   <= acc_d;
                        dbz_o   <= (dvs_q == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmp_add_div8.sv
// cmp_add_div8
// Registered adder and unsigned comparator running every cycle, plus a
// sequential divider sharing the same operands.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   a, b                    : operands (addend / compare / dividend, divisor)
//   div_start               : divide request
//   sum, cout               : registered a+b and its carry
//   bigger, equal, smallest : registered a>b, a==b, a<b
//   div_busy, div_done      : divider in progress / one-cycle completion pulse
//   quo, rem, div_by_zero   : divider results, held until the next done
module cmp_add_div8
    import cmp_add_div8_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             div_start,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             bigger,
    output logic             equal,
    output logic             smallest,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             bigger_q;
    logic             equal_q;
    logic             smallest_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            cout_q     <= 1'b0;
            bigger_q   <= 1'b0;
            equal_q    <= 1'b0;
            smallest_q <= 1'b0;
        end else begin
            {cout_q, sum_q} <= {1'b0, a} + {1'b0, b};
            bigger_q        <= (a > b);
            equal_q         <= (a == b);
            smallest_q      <= (a < b);
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign bigger   = bigger_q;
    assign equal    = equal_q;
    assign smallest = smallest_q;

    div8_seq #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (div_start),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quo_o   (quo),
        .rem_o   (rem),
        .dbz_o   (div_by_zero)
    );

endmodule

// File: tb/tb_cmp_add_div8.sv
module tb_cmp_add_div8;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       div_start;
    logic [7:0] sum;
    logic       cout;
    logic       bigger;
    logic       equal;
    logic       smallest;
    logic       div_busy;
    logic       div_done;
    logic [7:0] quo;
    logic [7:0] rem;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    cmp_add_div8 #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .div_start   (div_start),
        .sum         (sum),
        .cout        (cout),
        .bigger      (bigger),
        .equal       (equal),
        .smallest    (smallest),
        .div_busy    (div_busy),
        .div_done    (div_done),
        .quo         (quo),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance to 1 time unit past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_alu(input string tag, input logic [7:0] es, input logic ec,
                             input logic eb, input logic ee, input logic el);
        check({tag, ".sum"}, sum, es);
        check({tag, ".cout"}, cout, ec);
        check({tag, ".bigger"}, bigger, eb);
        check({tag, ".equal"}, equal, ee);
        check({tag, ".smallest"}, smallest, el);
    endtask

    // n0 = cycles already elapsed since the accepting edge
    task automatic wait_done(input string tag, input int n0, input logic [7:0] eq,
                             input logic [7:0] er, input logic ez);
        int n = n0;
        do begin
            tick();
            n++;
        end while (!div_done && n < 20);
        check({tag, ".latency"}, n, 8);
        check({tag, ".done"}, div_done, 1'b1);
        check({tag, ".busy_at_done"}, div_busy, 1'b0);
        check({tag, ".quo"}, quo, eq);
        check({tag, ".rem"}, rem, er);
        check({tag, ".dbz"}, div_by_zero, ez);
    endtask

    task automatic run_div(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic [7:0] eq, input logic [7:0] er, input logic ez);
        a = ta;
        b = tb_v;
        div_start = 1'b1;
        tick();
        check({tag, ".busy_accept"}, div_busy, 1'b1);
        check({tag, ".done_accept"}, div_done, 1'b0);
        div_start = 1'b0;
        wait_done(tag, 0, eq, er, ez);
    endtask

    initial begin
        rst_n     = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        div_start = 1'b0;
        #1;
        check("rst.sum", sum, 8'h00);
        check("rst.cout", cout, 1'b0);
        check("rst.cmp", {bigger, equal, smallest}, 3'b000);
        check("rst.div", {div_busy, div_done, div_by_zero}, 3'b000);
        check("rst.quo", quo, 8'h00);
        check("rst.rem", rem, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_alu("zero", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        a = 8'hC8; b = 8'h64;
        tick();
        check_alu("c8_64", 8'h2C, 1'b1, 1'b1, 1'b0, 1'b0);
        a = 8'h3C; b = 8'h3C;
        tick();
        check_alu("3c_3c", 8'h78, 1'b0, 1'b0, 1'b1, 1'b0);
        a = 8'h01; b = 8'hFF;
        tick();
        check_alu("01_ff", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // 100 / 7 = 14 r 2
        run_div("div64_07", 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0);
        tick();
        check("div64_07.done_pulse", div_done, 1'b0);
        check("div64_07.quo_hold", quo, 8'h0E);
        check("div64_07.rem_hold", rem, 8'h02);

        run_div("div2a_00", 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1);

        // 200 / 10 = 20 r 0, with operands and a second start mid-divide
        a = 8'hC8; b = 8'h0A; div_start = 1'b1;
        tick();
        check("busy.accept", div_busy, 1'b1);
        a = 8'h11; b = 8'h03;
        tick();
        tick();
        div_start = 1'b0;
        check("busy.still", div_busy, 1'b1);
        check_alu("during_div", 8'h14, 1'b0, 1'b1, 1'b0, 1'b0);
        check("busy.quo_hold", quo, 8'hFF);
        wait_done("divc8_0a", 2, 8'h14, 8'h00, 1'b0);
        // start in the done cycle: 17 / 3 = 5 r 2
        div_start = 1'b1;
        tick();
        check("b2b.busy", div_busy, 1'b1);
        check("b2b.done", div_done, 1'b0);
        div_start = 1'b0;
        wait_done("div11_03", 0, 8'h05, 8'h02, 1'b0);

        // reset at iteration 4 of a running divide
        a = 8'h64; b = 8'h07; div_start = 1'b1;
        tick();
        div_start = 1'b0;
        repeat (4) tick();
        check("abort.busy_before", div_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort.sum", sum, 8'h00);
        check("abort.cmp", {cout, bigger, equal, smallest}, 4'b0000);
        check("abort.div", {div_busy, div_done, div_by_zero}, 3'b000);
        check("abort.quo", quo, 8'h00);
        check("abort.rem", rem, 8'h00);
        #2;
        rst_n = 1'b1;
        // 255 / 16 = 15 r 15, accepted on the first edge after release
        run_div("divff_10", 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
